// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the mips instruction memory.
// Frame: N_hi, N_lo, 4*N data bytes (big-endian words), XOR checksum of data.
// Holds the core in reset until the whole image has landed and the checksum
// matches.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR} state_t;

  // Capacity in words. N equal to it is a legal, exactly-full image.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state, stateNxt;
  logic [7:0]        lenHi;
  logic [15:0]       nWords;
  logic [ADDR_W:0]   wordCnt;   // one extra bit so a full image can be counted
  logic [1:0]        byteCnt;
  logic [23:0]       shiftReg;
  logic [7:0]        csum;
  logic              accept;
  logic [16:0]       lenFull;
  logic [16:0]       wordNext;
  logic              lastWord;

  assign accept   = in_valid && in_ready;
  assign lenFull  = {1'b0, lenHi, in_data};
  assign wordNext = 17'(wordCnt) + 17'd1;
  assign lastWord = (wordNext == {1'b0, nWords});

  assign done      = (state == RUN);
  assign err       = (state == ERR);
  assign cpu_reset = (state != RUN);

  // Ready only in the stream-consuming states, and never during reset.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        LEN_HI, LEN_LO, DATA, CSUM: in_ready = 1'b1;
        default:                    in_ready = 1'b0;
      endcase
    end
  end

  // Next-state logic; every transition requires an accepted byte.
  always_comb begin
    stateNxt = state;
    if (accept) begin
      case (state)
        LEN_HI: stateNxt = LEN_LO;
        LEN_LO: begin
          if (lenFull > CAP)       stateNxt = ERR;
          else if (lenFull == '0)  stateNxt = CSUM;
          else                     stateNxt = DATA;
        end
        DATA:   if (byteCnt == 2'd3 && lastWord) stateNxt = CSUM;
        CSUM:   stateNxt = (in_data == csum) ? RUN : ERR;
        default: stateNxt = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LEN_HI;
    else       state <= stateNxt;
  end

  // Datapath: length capture, word assembly, checksum and the write strobe.
  // Address/data stay put after the strobe drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      lenHi      <= '0;
      nWords     <= '0;
      wordCnt    <= '0;
      byteCnt    <= '0;
      shiftReg   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          LEN_HI: lenHi  <= in_data;
          LEN_LO: nWords <= {lenHi, in_data};
          DATA: begin
            csum     <= csum ^ in_data;
            byteCnt  <= byteCnt + 2'd1;
            shiftReg <= {shiftReg[15:0], in_data};
            if (byteCnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= wordCnt[ADDR_W-1:0];
              imem_wdata <= {shiftReg, in_data};
              wordCnt    <= wordCnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, bad checksum, empty image,
// length boundaries, gapped input and reset mid-load.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  int weDouble = 0;
  int notReady = 0;
  int gapMax = 0;
  logic prevWe = 1'b0;
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Memory model: capture writes mid-cycle, flag any strobe longer than one cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      weCount++;
      if (prevWe) weDouble++;
    end
    prevWe = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte (after optional idle gap) for exactly one accepting edge.
  task automatic sendByte(input logic [7:0] b);
    int g;
    g = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    if (!in_ready) notReady++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("ready_in_reset", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    weCount = 0;
    weDouble = 0;
    notReady = 0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
  endtask

  task automatic sendTest1(input logic [7:0] cs);
    logic [7:0] s [0:9];
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    for (int i = 0; i < 10; i++) sendByte(s[i]);
    sendByte(cs);
  endtask

  task automatic checkTest1Done(input string tag);
    chk({tag, "_wecount"}, 32'(weCount), 2);
    chk({tag, "_mem0"}, mem[0], 32'h20080005);
    chk({tag, "_mem1"}, mem[1], 32'h2009000A);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_wedouble"}, 32'(weDouble), 0);
    chk({tag, "_notready"}, 32'(notReady), 0);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] w;
    int bad;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpurst", 32'(cpu_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);

    // 1: two-word load with explicit write-latency checks
    sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h20); sendByte(8'h08); sendByte(8'h00);
    chk("t1_no_early_we", 32'(imem_we), 0);
    sendByte(8'h05);
    chk("t1_we0", 32'(imem_we), 1);
    chk("t1_addr0", 32'(imem_addr), 0);
    chk("t1_wdata0", imem_wdata, 32'h20080005);
    sendByte(8'h20);
    chk("t1_we_drop", 32'(imem_we), 0);
    chk("t1_wdata_hold", imem_wdata, 32'h20080005);
    sendByte(8'h09); sendByte(8'h00); sendByte(8'h0A);
    chk("t1_addr1", 32'(imem_addr), 1);
    chk("t1_wdata1", imem_wdata, 32'h2009000A);
    chk("t1_cpurst_pre", 32'(cpu_reset), 1);
    sendByte(8'h0E);
    checkTest1Done("t1");
    chk("t1_addr_hold", 32'(imem_addr), 1);

    // Reset from RUN re-asserts cpu_reset at the reset edge
    reset = 1'b1;
    @(posedge clk); #1;
    chk("run_rst_cpurst", 32'(cpu_reset), 1);
    chk("run_rst_done", 32'(done), 0);

    // 2: bad checksum
    doReset();
    sendTest1(8'h0F);
    chk("t2_wecount", 32'(weCount), 2);
    chk("t2_mem1", mem[1], 32'h2009000A);
    chk("t2_err", 32'(err), 1);
    chk("t2_cpurst", 32'(cpu_reset), 1);
    chk("t2_ready", 32'(in_ready), 0);
    chk("t2_done", 32'(done), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i * 37);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t2_ignored_we", 32'(weCount), 2);
    chk("t2_err_stays", 32'(err), 1);

    // 3: empty images
    doReset();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    chk("t3a_wecount", 32'(weCount), 0);
    chk("t3a_done", 32'(done), 1);
    chk("t3a_cpurst", 32'(cpu_reset), 0);
    doReset();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    chk("t3b_err", 32'(err), 1);
    chk("t3b_done", 32'(done), 0);

    // 4a: full memory, N = 256
    doReset();
    sendByte(8'h01); sendByte(8'h00);
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'(i + 3)};
      for (int b = 3; b >= 0; b--) begin
        cs = cs ^ w[b*8 +: 8];
        sendByte(w[b*8 +: 8]);
      end
    end
    chk("t4a_cpurst_pre", 32'(cpu_reset), 1);
    sendByte(cs);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'(i + 3)};
      if (mem[i] !== w) bad++;
    end
    chk("t4a_wecount", 32'(weCount), 256);
    chk("t4a_mem_bad", 32'(bad), 0);
    chk("t4a_done", 32'(done), 1);
    chk("t4a_notready", 32'(notReady), 0);

    // 4b: N = 257 overflows right after the length
    doReset();
    sendByte(8'h01); sendByte(8'h01);
    chk("t4b_err", 32'(err), 1);
    chk("t4b_cpurst", 32'(cpu_reset), 1);
    @(posedge clk); #1;
    chk("t4b_ready", 32'(in_ready), 0);
    chk("t4b_wecount", 32'(weCount), 0);

    // 5: gapped input
    doReset();
    gapMax = 3;
    sendTest1(8'h0E);
    gapMax = 0;
    checkTest1Done("t5");

    // 6: reset after 6 data bytes, then full replay
    doReset();
    sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h20); sendByte(8'h08); sendByte(8'h00);
    sendByte(8'h05); sendByte(8'h20); sendByte(8'h09);
    chk("t6_partial_we", 32'(weCount), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6_ready", 32'(in_ready), 1);
    chk("t6_we", 32'(imem_we), 0);
    chk("t6_addr", 32'(imem_addr), 0);
    chk("t6_wdata", imem_wdata, 0);
    chk("t6_cpurst", 32'(cpu_reset), 1);
    chk("t6_done", 32'(done), 0);
    weCount = 0;
    sendTest1(8'h0E);
    checkTest1Done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
